// File: rtl/ps2_note_decoder.sv
// ps2_note_decoder: PS/2 scan codes -> held note gates, voice limit, octave, panic.
// Optional prefix timeout: define PS2_NOTE_TIMEOUT_EN.
// Ports: CLOCK_50, resetn (async low), received_data[7:0], received_data_en,
//   note_gate[NUM_NOTES], note_on, note_off, note_idx[5], octave[2],
//   voice_count, all_off, voices_full.
module ps2_note_decoder #(
  parameter int NUM_NOTES      = 24,
  parameter int MAX_VOICES     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  localparam int CW = $clog2(MAX_VOICES + 1)
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic [7:0]           received_data,
  input  logic                 received_data_en,
  output logic [NUM_NOTES-1:0] note_gate,
  output logic                 note_on,
  output logic                 note_off,
  output logic [4:0]           note_idx,
  output logic [1:0]           octave,
  output logic [CW-1:0]        voice_count,
  output logic                 all_off,
  output logic                 voices_full
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } state_t;

  localparam logic [7:0]    BRK_CODE = 8'hF0;
  localparam logic [7:0]    EXT_CODE = 8'hE0;
  localparam logic [5:0]    NN       = 6'(NUM_NOTES);
  localparam logic [CW-1:0] VMAX     = CW'(MAX_VOICES);

  state_t state;

`ifdef PS2_NOTE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tcnt;
`endif

  // {valid, index}
  function automatic logic [5:0] note_map(input logic [7:0] code);
    case (code)
      8'h15:   note_map = {1'b1, 5'd0};
      8'h1D:   note_map = {1'b1, 5'd1};
      8'h24:   note_map = {1'b1, 5'd2};
      8'h2D:   note_map = {1'b1, 5'd3};
      8'h2C:   note_map = {1'b1, 5'd4};
      8'h35:   note_map = {1'b1, 5'd5};
      8'h3C:   note_map = {1'b1, 5'd6};
      8'h43:   note_map = {1'b1, 5'd7};
      8'h44:   note_map = {1'b1, 5'd8};
      8'h4D:   note_map = {1'b1, 5'd9};
      8'h1C:   note_map = {1'b1, 5'd10};
      8'h1B:   note_map = {1'b1, 5'd11};
      8'h23:   note_map = {1'b1, 5'd12};
      8'h2B:   note_map = {1'b1, 5'd13};
      8'h34:   note_map = {1'b1, 5'd14};
      8'h33:   note_map = {1'b1, 5'd15};
      8'h3B:   note_map = {1'b1, 5'd16};
      8'h42:   note_map = {1'b1, 5'd17};
      8'h4B:   note_map = {1'b1, 5'd18};
      8'h1A:   note_map = {1'b1, 5'd19};
      8'h22:   note_map = {1'b1, 5'd20};
      8'h21:   note_map = {1'b1, 5'd21};
      8'h2A:   note_map = {1'b1, 5'd22};
      8'h32:   note_map = {1'b1, 5'd23};
      default: note_map = 6'd0;
    endcase
  endfunction

  logic [5:0]           map;
  logic [4:0]           nidx;
  logic                 is_note;
  logic [NUM_NOTES-1:0] mask;
  logic                 held;
  logic                 is_brk;
  logic                 is_ext;
  logic                 is_oct0;
  logic                 is_oct1;
  logic                 is_oct2;
  logic                 is_panic;

  always_comb begin
    map     = note_map(received_data);
    nidx    = map[4:0];
    // indices beyond the configured note count behave as unmapped
    is_note = map[5] && ({1'b0, nidx} < NN);
    mask    = '0;
    for (int i = 0; i < NUM_NOTES; i++)
      mask[i] = is_note && (nidx == 5'(i));
    held     = |(note_gate & mask);
    is_brk   = received_data == BRK_CODE;
    is_ext   = received_data == EXT_CODE;
    is_oct0  = received_data == 8'h16;
    is_oct1  = received_data == 8'h1E;
    is_oct2  = received_data == 8'h26;
    is_panic = received_data == 8'h76;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      note_gate   <= '0;
      note_on     <= 1'b0;
      note_off    <= 1'b0;
      note_idx    <= 5'd0;
      octave      <= 2'd1;
      voice_count <= '0;
      all_off     <= 1'b0;
      voices_full <= 1'b0;
`ifdef PS2_NOTE_TIMEOUT_EN
      tcnt        <= '0;
`endif
    end else begin
      note_on  <= 1'b0;
      note_off <= 1'b0;
      all_off  <= 1'b0;
      if (received_data_en) begin
`ifdef PS2_NOTE_TIMEOUT_EN
        tcnt <= '0;
`endif
        unique case (state)
          S_IDLE: begin
            unique case (1'b1)
              is_brk: state <= S_BRK;
              is_ext: state <= S_EXT;
              is_note: begin
                // repeats and voice overflow are dropped silently
                if (!held && !voices_full) begin
                  note_gate   <= note_gate | mask;
                  voice_count <= voice_count + CW'(1);
                  voices_full <= (voice_count + CW'(1)) == VMAX;
                  note_on     <= 1'b1;
                  note_idx    <= nidx;
                end
              end
              is_oct0: octave <= 2'd0;
              is_oct1: octave <= 2'd1;
              is_oct2: octave <= 2'd2;
              is_panic: begin
                note_gate   <= '0;
                voice_count <= '0;
                voices_full <= 1'b0;
                all_off     <= 1'b1;
              end
              default: ;
            endcase
          end
          S_BRK: begin
            state <= S_IDLE;
            if (held) begin
              note_gate   <= note_gate & ~mask;
              voice_count <= voice_count - CW'(1);
              voices_full <= 1'b0;
              note_off    <= 1'b1;
              note_idx    <= nidx;
            end
          end
          S_EXT:     state <= is_brk ? S_EXT_BRK : S_IDLE;
          S_EXT_BRK: state <= S_IDLE;
          default:   state <= S_IDLE;
        endcase
      end
`ifdef PS2_NOTE_TIMEOUT_EN
      else if (state != S_IDLE) begin
        // stale prefix: abandon it without touching outputs
        if (tcnt == TLIM) begin
          state <= S_IDLE;
          tcnt  <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end else begin
        tcnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_note_decoder.sv
// tb_ps2_note_decoder: directed scan-code sequences with hand-computed results.
// Second instance runs with NUM_NOTES=12.
module tb_ps2_note_decoder;

  logic        CLOCK_50 = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  received_data = 8'h00;
  logic        received_data_en = 1'b0;

  logic [23:0] note_gate;
  logic        note_on;
  logic        note_off;
  logic [4:0]  note_idx;
  logic [1:0]  octave;
  logic [2:0]  voice_count;
  logic        all_off;
  logic        voices_full;

  logic [11:0] g12;
  logic        on12;
  logic        off12;
  logic [4:0]  idx12;
  logic [1:0]  oct12;
  logic [2:0]  vc12;
  logic        ao12;
  logic        vf12;

  int n_chk = 0;
  int n_err = 0;
  int on_cnt = 0;
  int off_cnt = 0;
  int ao_cnt = 0;
  int b_on;
  int b_off;
  int b_ao;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_note_decoder #(
    .NUM_NOTES(24), .MAX_VOICES(4), .TIMEOUT_CYCLES(100)
  ) u_dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .received_data(received_data), .received_data_en(received_data_en),
    .note_gate(note_gate), .note_on(note_on), .note_off(note_off),
    .note_idx(note_idx), .octave(octave), .voice_count(voice_count),
    .all_off(all_off), .voices_full(voices_full)
  );

  ps2_note_decoder #(
    .NUM_NOTES(12), .MAX_VOICES(4), .TIMEOUT_CYCLES(100)
  ) u_dut12 (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .received_data(received_data), .received_data_en(received_data_en),
    .note_gate(g12), .note_on(on12), .note_off(off12),
    .note_idx(idx12), .octave(oct12), .voice_count(vc12),
    .all_off(ao12), .voices_full(vf12)
  );

  // strobe counters; read pre-update values at the edge
  always @(posedge CLOCK_50) begin
    if (note_on)  on_cnt++;
    if (note_off) off_cnt++;
    if (all_off)  ao_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge CLOCK_50);
    received_data    = b;
    received_data_en = 1'b1;
  endtask

  task automatic drop();
    @(negedge CLOCK_50);
    received_data_en = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    put(b);
    drop();
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
  endtask

  task automatic mark();
    idle(2);
    b_on  = on_cnt;
    b_off = off_cnt;
    b_ao  = ao_cnt;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_gate", note_gate, 0);
    chk("rst_on", note_on, 0);
    chk("rst_off", note_off, 0);
    chk("rst_ao", all_off, 0);
    chk("rst_idx", note_idx, 0);
    chk("rst_oct", octave, 1);
    chk("rst_cnt", voice_count, 0);
    chk("rst_full", voices_full, 0);

    // single make / break
    send(8'h15);
    chk("mk_gate", note_gate, 24'h000001);
    chk("mk_on", note_on, 1);
    chk("mk_idx", note_idx, 0);
    chk("mk_cnt", voice_count, 1);
    send(8'hF0);
    send(8'h15);
    chk("bk_gate", note_gate, 0);
    chk("bk_off", note_off, 1);
    chk("bk_on", note_on, 0);
    chk("bk_idx", note_idx, 0);
    chk("bk_cnt", voice_count, 0);

    // voice limit
    mark();
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    send(8'h2C);
    chk("vf_on5", note_on, 0);
    idle(2);
    chk("vf_gate", note_gate, 24'h00000F);
    chk("vf_full", voices_full, 1);
    chk("vf_cnt", voice_count, 4);
    chk("vf_ons", on_cnt - b_on, 4);
    send(8'hF0);
    send(8'h24);
    chk("vb_off", note_off, 1);
    chk("vb_idx", note_idx, 2);
    chk("vb_gate", note_gate, 24'h00000B);
    chk("vb_full", voices_full, 0);
    send(8'h2C);
    chk("vm_on", note_on, 1);
    chk("vm_idx", note_idx, 4);
    chk("vm_gate", note_gate, 24'h00001B);
    chk("vm_cnt", voice_count, 4);
    chk("vm_full", voices_full, 1);
    send(8'h76);
    chk("vp_gate", note_gate, 0);

    // typematic repeat and extended codes
    mark();
    send(8'h43);
    send(8'h43);
    send(8'h43);
    send(8'hE0);
    send(8'h43);
    send(8'hE0);
    send(8'hF0);
    send(8'h43);
    idle(2);
    chk("rp_ons", on_cnt - b_on, 1);
    chk("rp_offs", off_cnt - b_off, 0);
    chk("rp_idx", note_idx, 7);
    chk("rp_gate", note_gate, 24'h000080);
    chk("rp_cnt", voice_count, 1);

    // break of a clear gate: no underflow
    send(8'hF0);
    send(8'h43);
    mark();
    send(8'hF0);
    send(8'h1D);
    idle(2);
    chk("uf_cnt", voice_count, 0);
    chk("uf_offs", off_cnt - b_off, 0);

    // panic, octave
    send(8'h1C);
    send(8'h32);
    chk("pn_hold", note_gate, 24'h800400);
    chk("pn_cnt2", voice_count, 2);
    mark();
    send(8'h76);
    chk("pn_ao", all_off, 1);
    chk("pn_gate", note_gate, 0);
    chk("pn_cnt", voice_count, 0);
    idle(2);
    chk("pn_aos", ao_cnt - b_ao, 1);
    chk("pn_offs", off_cnt - b_off, 0);
    send(8'h26);
    chk("oc_2", octave, 2);
    send(8'h15);
    send(8'h16);
    chk("oc_0", octave, 0);
    chk("oc_gate", note_gate, 24'h000001);
    send(8'hF0);
    send(8'h1E);
    chk("oc_brk", octave, 0);
    send(8'h76);

    // back-to-back strobes
    put(8'h15);
    put(8'h1D);
    drop();
    chk("bb_gate", note_gate, 24'h000003);
    chk("bb_idx", note_idx, 1);
    put(8'hF0);
    put(8'h15);
    drop();
    chk("bb_off", note_off, 1);
    chk("bb_gate2", note_gate, 24'h000002);
    send(8'h76);

    // NUM_NOTES = 12 instance
    do_reset();
    send(8'h23);
    chk("n12_on", on12, 0);
    chk("n12_g0", g12, 0);
    send(8'hF0);
    send(8'h1B);
    chk("n12_off", off12, 0);
    chk("n12_cnt", vc12, 0);
    send(8'h1B);
    chk("n12_mk", g12, 12'h800);
    chk("n12_idx", idx12, 11);

    // stale break prefix
    do_reset();
    send(8'hF0);
    idle(100);
    send(8'h15);
`ifdef PS2_NOTE_TIMEOUT_EN
    chk("to_on", note_on, 1);
    chk("to_gate", note_gate, 24'h000001);
`else
    chk("to_on", note_on, 0);
    chk("to_gate", note_gate, 0);
`endif
    send(8'h76);

    // reset in the middle of a break sequence
    send(8'hF0);
    idle(1);
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
    send(8'h15);
    chk("mr_on", note_on, 1);
    chk("mr_gate", note_gate, 24'h000001);
    chk("mr_idx", note_idx, 0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
